// File: rtl/alu_md_pkg.sv
// ---------------------------------------------------------------------------
// alu_md_pkg
// Shared encodings for the execute-stage ALU and its multiply/divide unit:
//   - aluop codes  (ALU_ADD .. ALU_MOVZ)
//   - md_op codes  (MD_NONE .. MD_MTLO)
//   - MD FSM state encoding (S_IDLE, S_MUL, S_DIV)
// ---------------------------------------------------------------------------
package alu_md_pkg;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_RSV  = 4'h4;
  localparam logic [3:0] ALU_LUI  = 4'h5;
  localparam logic [3:0] ALU_XOR  = 4'h6;
  localparam logic [3:0] ALU_NOR  = 4'h7;
  localparam logic [3:0] ALU_SLL  = 4'h8;
  localparam logic [3:0] ALU_SLLV = 4'h9;
  localparam logic [3:0] ALU_SRL  = 4'hA;
  localparam logic [3:0] ALU_SRLV = 4'hB;
  localparam logic [3:0] ALU_SLT  = 4'hC;
  localparam logic [3:0] ALU_SLTU = 4'hD;
  localparam logic [3:0] ALU_SRA  = 4'hE;
  localparam logic [3:0] ALU_MOVZ = 4'hF;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } md_state_e;

endpackage

// File: rtl/alu_md_core.sv
// ---------------------------------------------------------------------------
// alu_md_core
// Purely combinational ALU datapath.
// Optional feature macro: ALU_MD_OVF_EN (adds ovf_o signed add/sub overflow).
// Ports:
//   a_i      in  WIDTH  operand A (rs)
//   b_i      in  WIDTH  operand B (rt/imm)
//   aluop_i  in  4      operation select
//   shamt_i  in  SHW    immediate shift amount
//   y_o      out WIDTH  result
//   ovf_o    out 1      signed overflow for add/sub (ALU_MD_OVF_EN only)
// ---------------------------------------------------------------------------
module alu_md_core
  import alu_md_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       aluop_i,
  input  logic [SHW-1:0]   shamt_i,
`ifdef ALU_MD_OVF_EN
  output logic             ovf_o,
`endif
  output logic [WIDTH-1:0] y_o
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [SHW-1:0]   vsh;

  assign sum  = a_i + b_i;
  assign diff = a_i - b_i;
  // Variable shifts take their amount from the low bits of rs.
  assign vsh  = a_i[SHW-1:0];

  always_comb begin
    y_o = '0;
    case (aluop_i)
      ALU_ADD:  y_o = sum;
      ALU_SUB:  y_o = diff;
      ALU_AND:  y_o = a_i & b_i;
      ALU_OR:   y_o = a_i | b_i;
      ALU_LUI:  y_o = {b_i[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      ALU_XOR:  y_o = a_i ^ b_i;
      ALU_NOR:  y_o = ~(a_i | b_i);
      ALU_SLL:  y_o = b_i << shamt_i;
      ALU_SLLV: y_o = b_i << vsh;
      ALU_SRL:  y_o = b_i >> shamt_i;
      ALU_SRLV: y_o = b_i >> vsh;
      ALU_SLT:  y_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU: y_o = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
      ALU_SRA:  y_o = $signed(b_i) >>> shamt_i;
      ALU_MOVZ: y_o = (b_i == '0) ? a_i : '0;
      default:  y_o = '0;
    endcase
  end

`ifdef ALU_MD_OVF_EN
  always_comb begin
    ovf_o = 1'b0;
    if (aluop_i == ALU_ADD)
      ovf_o = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
    else if (aluop_i == ALU_SUB)
      ovf_o = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
  end
`endif

endmodule

// File: rtl/alu_md.sv
// ---------------------------------------------------------------------------
// alu_md
// Execute-stage ALU plus multi-cycle multiply/divide unit with HI/LO.
// The ALU result is combinational; HI/LO update on a clock edge.
// Optional feature macro: ALU_MD_OVF_EN (adds the ovf output).
// Ports:
//   clk         in  1      rising-edge clock
//   rst_n       in  1      asynchronous active-low reset
//   data1_E     in  WIDTH  operand A (rs)
//   data2_E     in  WIDTH  operand B (rt/imm)
//   aluop       in  4      ALU op select
//   s_alu       in  SHW    shamt for sll/srl/sra
//   md_op       in  3      multiply/divide/move op
//   md_start    in  1      qualifies md_op for one cycle
//   data_alu_E  out WIDTH  combinational ALU result
//   busy        out 1      MD unit computing (stall source)
//   hi, lo      out WIDTH  HI/LO registers
//   ovf         out 1      signed add/sub overflow (ALU_MD_OVF_EN only)
// ---------------------------------------------------------------------------
module alu_md
  import alu_md_pkg::*;
#(
  parameter  int WIDTH   = 32,
  parameter  int MUL_LAT = 5,
  parameter  int DIV_LAT = 10,
  localparam int SHW     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data1_E,
  input  logic [WIDTH-1:0] data2_E,
  input  logic [3:0]       aluop,
  input  logic [SHW-1:0]   s_alu,
  input  logic [2:0]       md_op,
  input  logic             md_start,
  output logic [WIDTH-1:0] data_alu_E,
  output logic             busy,
`ifdef ALU_MD_OVF_EN
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXLAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW     = (MAXLAT > 1) ? $clog2(MAXLAT) : 1;

  // ------------------------------------------------------------------ ALU
  alu_md_core #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_core (
    .a_i     (data1_E),
    .b_i     (data2_E),
    .aluop_i (aluop),
    .shamt_i (s_alu),
`ifdef ALU_MD_OVF_EN
    .ovf_o   (ovf),
`endif
    .y_o     (data_alu_E)
  );

  // ------------------------------------------------------ MD arithmetic
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic               div_signed;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, b_safe;
  logic [WIDTH-1:0]   q_mag, r_mag;
  logic [WIDTH-1:0]   quot, rem;

  // Sign-extending to 2*WIDTH makes the low 2*WIDTH bits of an unsigned
  // multiply equal to the signed product.
  assign prod_s = {{WIDTH{data1_E[WIDTH-1]}}, data1_E} * {{WIDTH{data2_E[WIDTH-1]}}, data2_E};
  assign prod_u = {{WIDTH{1'b0}}, data1_E} * {{WIDTH{1'b0}}, data2_E};

  // Signed divide via magnitudes. MIN/-1 falls out as quotient MIN,
  // remainder 0: |MIN| reads as 2^(WIDTH-1) unsigned, and negating it
  // yields MIN again.
  assign div_signed = (md_op == MD_DIV);
  assign a_neg      = div_signed & data1_E[WIDTH-1];
  assign b_neg      = div_signed & data2_E[WIDTH-1];
  assign a_mag      = a_neg ? -data1_E : data1_E;
  assign b_mag      = b_neg ? -data2_E : data2_E;
  // Keeps the divider free of X on divide-by-zero; the result is discarded.
  assign b_safe     = (b_mag == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
  assign q_mag      = a_mag / b_safe;
  assign r_mag      = a_mag % b_safe;
  assign quot       = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem        = a_neg ? -r_mag : r_mag;

  // ------------------------------------------------------------- FSM
  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic             res_wr_q, res_wr_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  assign busy = (state_q != S_IDLE);
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      res_wr_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      res_wr_q <= res_wr_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    res_wr_d = res_wr_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      S_IDLE: begin
        if (md_start) begin
          case (md_op)
            MD_MULT, MD_MULTU: begin
              state_d              = S_MUL;
              cnt_d                = CW'(MUL_LAT - 1);
              {res_hi_d, res_lo_d} = (md_op == MD_MULT) ? prod_s : prod_u;
              res_wr_d             = 1'b1;
            end
            MD_DIV, MD_DIVU: begin
              state_d  = S_DIV;
              cnt_d    = CW'(DIV_LAT - 1);
              res_hi_d = rem;
              res_lo_d = quot;
              // Divide by zero still occupies the unit but leaves HI/LO alone.
              res_wr_d = (data2_E != '0);
            end
            MD_MTHI: hi_d = data1_E;
            MD_MTLO: lo_d = data1_E;
            default: ;
          endcase
        end
      end
      S_MUL, S_DIV: begin
        // md_start is not looked at here: the pipeline must stall on busy.
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          if (res_wr_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_md.sv
module tb_alu_md;
  import alu_md_pkg::*;

  localparam int W = 32;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  data1_E;
  logic [W-1:0]  data2_E;
  logic [3:0]    aluop;
  logic [4:0]    s_alu;
  logic [2:0]    md_op;
  logic          md_start;
  logic [W-1:0]  data_alu_E;
  logic          busy;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
`ifdef ALU_MD_OVF_EN
  logic          ovf;
`endif

  int cmp_count  = 0;
  int fail_count = 0;

  alu_md #(
    .WIDTH   (W),
    .MUL_LAT (5),
    .DIV_LAT (10)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data1_E    (data1_E),
    .data2_E    (data2_E),
    .aluop      (aluop),
    .s_alu      (s_alu),
    .md_op      (md_op),
    .md_start   (md_start),
    .data_alu_E (data_alu_E),
    .busy       (busy),
`ifdef ALU_MD_OVF_EN
    .ovf        (ovf),
`endif
    .hi         (hi),
    .lo         (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts busy cycles observed, starting with the current one.
  task automatic wait_done(output int n);
    n = 0;
    while (busy && n < 64) begin
      n++;
      tick();
    end
    cmp_count++;
    if (busy !== 1'b0) begin
      fail_count++;
      $display("FAIL busy_timeout: busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic start_md(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    md_op    = op;
    data1_E  = a;
    data2_E  = b;
    md_start = 1'b1;
    tick();
    md_start = 1'b0;
    md_op    = MD_NONE;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    data1_E  = '0;
    data2_E  = '0;
    aluop    = 4'h0;
    s_alu    = '0;
    md_op    = MD_NONE;
    md_start = 1'b0;
    #12;
    cmp_count++;
    if ({busy, hi, lo} !== {1'b0, 32'h0, 32'h0}) begin
      fail_count++;
      $display("FAIL reset_hold: busy=%b hi=%h lo=%h, required 0/0/0", busy, hi, lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    cmp_count++;
    if ({busy, hi, lo} !== {1'b0, 32'h0, 32'h0}) begin
      fail_count++;
      $display("FAIL reset_release: busy=%b hi=%h lo=%h, required 0/0/0", busy, hi, lo);
    end
    $display("reset: busy=%b hi=%h lo=%h", busy, hi, lo);
  endtask

  task automatic test_alu();
    logic [3:0]   vop [18];
    logic [W-1:0] va  [18];
    logic [W-1:0] vb  [18];
    logic [4:0]   vs  [18];
    logic [W-1:0] vy  [18];
    vop = '{4'hE, 4'hA, 4'h0, 4'h1, 4'h2, 4'h3, 4'h6, 4'h7, 4'h5,
            4'h8, 4'h9, 4'hB, 4'hC, 4'hD, 4'h4, 4'hF, 4'hF, 4'hE};
    va  = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'hF0F0_1234, 32'hF0F0_1234,
            32'hFF00_FF00, 32'h0F0F_0000, 32'h0, 32'h0, 32'h0000_0024,
            32'h0000_0008, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234, 32'hCAFE,
            32'hCAFE, 32'h0};
    vb  = '{32'h8000_0000, 32'h8000_0000, 32'h1, 32'h1, 32'h0FF0_FF00,
            32'h0FF0_FF00, 32'h0FF0_0FF0, 32'h00F0_000F, 32'hABCD_1234,
            32'h1, 32'h3, 32'h8000_0000, 32'h1, 32'h1, 32'h5678, 32'h0,
            32'h1, 32'h7000_0000};
    vs  = '{5'd4, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0,
            5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd31};
    vy  = '{32'hF800_0000, 32'h0800_0000, 32'h0, 32'hFFFF_FFFF, 32'h00F0_1200,
            32'hFFF0_FF34, 32'hF0F0_F0F0, 32'hF000_FFF0, 32'h1234_0000,
            32'h8000_0000, 32'h0000_0030, 32'h0080_0000, 32'h1, 32'h0, 32'h0,
            32'hCAFE, 32'h0, 32'h0};
    for (int i = 0; i < 18; i++) begin
      aluop   = vop[i];
      data1_E = va[i];
      data2_E = vb[i];
      s_alu   = vs[i];
      #1;
      $display("alu: op=%h a=%h b=%h s=%0d -> %h", vop[i], va[i], vb[i], vs[i], data_alu_E);
      cmp_count++;
      if (data_alu_E !== vy[i]) begin
        fail_count++;
        $display("FAIL alu_op%h_vec%0d: got %h, required %h", vop[i], i, data_alu_E, vy[i]);
      end
    end
    aluop = 4'h0;
  endtask

  task automatic test_mult();
    int n;
    start_md(MD_MULT, 32'hFFFF_FFFD, 32'h7);
    wait_done(n);
    $display("mult: -3*7 busy=%0d hi=%h lo=%h", n, hi, lo);
    cmp_count++;
    if (n != 5) begin
      fail_count++;
      $display("FAIL mult_busy_cycles: got %0d, required 5", n);
    end
    cmp_count++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      fail_count++;
      $display("FAIL mult_result: got %h_%h, required ffffffff_ffffffeb", hi, lo);
    end
    start_md(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(n);
    $display("multu: ffffffff^2 busy=%0d hi=%h lo=%h", n, hi, lo);
    cmp_count++;
    if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
      fail_count++;
      $display("FAIL multu_result: got %h_%h, required fffffffe_00000001", hi, lo);
    end
  endtask

  task automatic test_div();
    int n;
    start_md(MD_DIV, 32'hFFFF_FFF9, 32'h2);
    wait_done(n);
    $display("div: -7/2 busy=%0d hi=%h lo=%h", n, hi, lo);
    cmp_count++;
    if (n != 10) begin
      fail_count++;
      $display("FAIL div_busy_cycles: got %0d, required 10", n);
    end
    cmp_count++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      fail_count++;
      $display("FAIL div_neg_result: got %h_%h, required ffffffff_fffffffd", hi, lo);
    end
    start_md(MD_DIVU, 32'h7, 32'h0);
    wait_done(n);
    $display("divu: 7/0 busy=%0d hi=%h lo=%h", n, hi, lo);
    cmp_count++;
    if (n != 10) begin
      fail_count++;
      $display("FAIL div0_busy_cycles: got %0d, required 10", n);
    end
    cmp_count++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      fail_count++;
      $display("FAIL div0_unchanged: got %h_%h, required ffffffff_fffffffd", hi, lo);
    end
    start_md(MD_DIV, 32'h7, 32'hFFFF_FFFE);
    wait_done(n);
    $display("div: 7/-2 hi=%h lo=%h", hi, lo);
    cmp_count++;
    if ({hi, lo} !== 64'h0000_0001_FFFF_FFFD) begin
      fail_count++;
      $display("FAIL div_negdivisor: got %h_%h, required 00000001_fffffffd", hi, lo);
    end
    start_md(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n);
    $display("div: MIN/-1 hi=%h lo=%h", hi, lo);
    cmp_count++;
    if ({hi, lo} !== 64'h0000_0000_8000_0000) begin
      fail_count++;
      $display("FAIL div_min_over_m1: got %h_%h, required 00000000_80000000", hi, lo);
    end
    start_md(MD_DIVU, 32'hFFFF_FFF9, 32'h2);
    wait_done(n);
    $display("divu: fffffff9/2 hi=%h lo=%h", hi, lo);
    cmp_count++;
    if ({hi, lo} !== 64'h0000_0001_7FFF_FFFC) begin
      fail_count++;
      $display("FAIL divu_result: got %h_%h, required 00000001_7ffffffc", hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    start_md(MD_DIV, 32'd100, 32'd7);   // now in busy cycle 1
    tick();                              // busy cycle 2
    md_op    = MD_MULT;
    data1_E  = 32'd5;
    data2_E  = 32'd6;
    md_start = 1'b1;
    tick();
    md_start = 1'b0;
    md_op    = MD_NONE;
    wait_done(n);
    $display("b2b: div 100/7 with mult at cycle 2 busy=%0d hi=%h lo=%h", n + 2, hi, lo);
    cmp_count++;
    if (n + 2 != 10) begin
      fail_count++;
      $display("FAIL b2b_busy_cycles: got %0d, required 10", n + 2);
    end
    cmp_count++;
    if ({hi, lo} !== {32'd2, 32'd14}) begin
      fail_count++;
      $display("FAIL b2b_result: got %h_%h, required 00000002_0000000e", hi, lo);
    end
    tick();
    cmp_count++;
    if (busy !== 1'b0) begin
      fail_count++;
      $display("FAIL b2b_no_restart: busy=%b, required 0", busy);
    end
    start_md(MD_MTLO, 32'h1234, 32'h0);
    $display("mtlo: 1234 busy=%b hi=%h lo=%h", busy, hi, lo);
    cmp_count++;
    if ({busy, hi, lo} !== {1'b0, 32'd2, 32'h1234}) begin
      fail_count++;
      $display("FAIL mtlo: busy=%b hi=%h lo=%h, required 0/00000002/00001234", busy, hi, lo);
    end
    start_md(MD_MTHI, 32'hABCD, 32'h0);
    $display("mthi: abcd busy=%b hi=%h lo=%h", busy, hi, lo);
    cmp_count++;
    if ({busy, hi, lo} !== {1'b0, 32'hABCD, 32'h1234}) begin
      fail_count++;
      $display("FAIL mthi: busy=%b hi=%h lo=%h, required 0/0000abcd/00001234", busy, hi, lo);
    end
    start_md(3'd7, 32'h5555, 32'h1);
    cmp_count++;
    if ({busy, hi, lo} !== {1'b0, 32'hABCD, 32'h1234}) begin
      fail_count++;
      $display("FAIL mdop7_noeffect: busy=%b hi=%h lo=%h, required 0/0000abcd/00001234", busy, hi, lo);
    end
  endtask

  task automatic test_async_reset();
    int n;
    start_md(MD_DIV, 32'd50, 32'd3);    // busy cycle 1
    tick();
    tick();                              // busy cycle 3
    rst_n = 1'b0;
    #1;
    $display("async reset mid-div: busy=%b hi=%h lo=%h", busy, hi, lo);
    cmp_count++;
    if ({busy, hi, lo} !== {1'b0, 32'h0, 32'h0}) begin
      fail_count++;
      $display("FAIL async_reset: busy=%b hi=%h lo=%h, required 0/0/0", busy, hi, lo);
    end
    #2;
    rst_n = 1'b1;
    tick();
    start_md(MD_MULT, 32'h0001_0000, 32'h0001_0000);
    wait_done(n);
    $display("mult after reset: busy=%0d hi=%h lo=%h", n, hi, lo);
    cmp_count++;
    if (n != 5 || {hi, lo} !== 64'h0000_0001_0000_0000) begin
      fail_count++;
      $display("FAIL post_reset_mult: busy=%0d hi=%h lo=%h, required 5/00000001/00000000", n, hi, lo);
    end
  endtask

`ifdef ALU_MD_OVF_EN
  task automatic test_ovf();
    logic [3:0]   vop [5];
    logic [W-1:0] va  [5];
    logic [W-1:0] vb  [5];
    logic         vo  [5];
    vop = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h2};
    va  = '{32'h7FFF_FFFF, 32'h0, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF};
    vb  = '{32'h1, 32'h1, 32'h1, 32'h8000_0000, 32'h1};
    vo  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      aluop   = vop[i];
      data1_E = va[i];
      data2_E = vb[i];
      #1;
      $display("ovf: op=%h a=%h b=%h -> y=%h ovf=%b", vop[i], va[i], vb[i], data_alu_E, ovf);
      cmp_count++;
      if (ovf !== vo[i]) begin
        fail_count++;
        $display("FAIL ovf_vec%0d: got %b, required %b", i, ovf, vo[i]);
      end
    end
    aluop   = 4'h0;
    data1_E = 32'h7FFF_FFFF;
    data2_E = 32'h1;
    #1;
    cmp_count++;
    if (data_alu_E !== 32'h8000_0000) begin
      fail_count++;
      $display("FAIL ovf_add_result: got %h, required 80000000", data_alu_E);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_mult();
    test_div();
    test_back_to_back();
    test_async_reset();
`ifdef ALU_MD_OVF_EN
    test_ovf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
